// File: rtl/decode_pkg.sv
// Shared types for the decode queue: instruction classes, RV opcodes and the
// decoded-field record that the queue stores per entry.
package decode_pkg;

    typedef enum logic [2:0] {
        TYPE_ERROR = 3'd0,
        TYPE_R     = 3'd1,
        TYPE_I     = 3'd2,
        TYPE_S     = 3'd3,
        TYPE_B     = 3'd4,
        TYPE_U     = 3'd5,
        TYPE_J     = 3'd6
    } inst_type_e;

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_FENCE     = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

    // Immediate is kept outside the record because its width follows XLEN.
    typedef struct packed {
        inst_type_e  typ;
        logic        illegal;
        logic [6:0]  opcode;
        logic [6:0]  funct7;
        logic [2:0]  funct3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } decoded_t;

    // Every legal opcode ends in 2'b11, so compressed encodings fall to ERROR.
    function automatic inst_type_e opc_type(input logic [6:0] opc, input logic rv64);
        inst_type_e t;
        case (opc)
            OPC_OP:                                         t = TYPE_R;
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM,
            OPC_FENCE:                                      t = TYPE_I;
            OPC_STORE:                                      t = TYPE_S;
            OPC_BRANCH:                                     t = TYPE_B;
            OPC_LUI, OPC_AUIPC:                             t = TYPE_U;
            OPC_JAL:                                        t = TYPE_J;
            OPC_OP_IMM_32:                                  t = rv64 ? TYPE_I : TYPE_ERROR;
            OPC_OP_32:                                      t = rv64 ? TYPE_R : TYPE_ERROR;
            default:                                        t = TYPE_ERROR;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/decode_fields.sv
// Combinational RV32I/RV64I field extractor: raw instruction to decoded record
// plus the XLEN-wide sign-extended immediate.
module decode_fields
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instruction,
    output decoded_t        o_fields,
    output logic [XLEN-1:0] o_imm
);

    logic [31:0] inst;
    inst_type_e  typ;

    assign inst = i_instruction;
    assign typ  = opc_type(inst[6:0], XLEN == 64);

    always_comb begin
        o_fields        = '0;
        o_imm           = '0;
        o_fields.opcode = inst[6:0];
        o_fields.typ    = typ;
        // Size casts of signed operands replicate inst[31] up to XLEN.
        case (typ)
            TYPE_R: begin
                o_fields.funct7 = inst[31:25];
                o_fields.funct3 = inst[14:12];
                o_fields.rs1    = inst[19:15];
                o_fields.rs2    = inst[24:20];
                o_fields.rd     = inst[11:7];
            end
            TYPE_I: begin
                o_fields.funct3 = inst[14:12];
                o_fields.rs1    = inst[19:15];
                o_fields.rd     = inst[11:7];
                o_imm           = XLEN'($signed(inst[31:20]));
            end
            TYPE_S: begin
                o_fields.funct3 = inst[14:12];
                o_fields.rs1    = inst[19:15];
                o_fields.rs2    = inst[24:20];
                o_imm           = XLEN'($signed({inst[31:25], inst[11:7]}));
            end
            TYPE_B: begin
                o_fields.funct3 = inst[14:12];
                o_fields.rs1    = inst[19:15];
                o_fields.rs2    = inst[24:20];
                o_imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
            end
            TYPE_U: begin
                o_fields.rd = inst[11:7];
                o_imm       = XLEN'($signed({inst[31:12], 12'b0}));
            end
            TYPE_J: begin
                o_fields.rd = inst[11:7];
                o_imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
            end
            default: begin
                o_fields.typ     = TYPE_ERROR;
                o_fields.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decode_queue.sv
// Decode stage with a DEPTH-entry queue of decoded beats and valid/ready on both
// sides. Define DECODE_PERF_EN to add decoded/illegal push counters.
module decode_queue
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_flush,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [31:0]              i_instruction,
    input  logic [XLEN-1:0]          i_pc,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [XLEN-1:0]          o_pc,
    output logic [6:0]               o_opcode,
    output logic [6:0]               o_funct7,
    output logic [2:0]               o_funct3,
    output logic [4:0]               o_rs1,
    output logic [4:0]               o_rs2,
    output logic [4:0]               o_rd,
    output logic [XLEN-1:0]          o_imm,
    output inst_type_e               o_type,
    output logic                     o_illegal,
    output logic [$clog2(DEPTH):0]   o_count
`ifdef DECODE_PERF_EN
    ,
    output logic [31:0]              o_perf_decoded,
    output logic [31:0]              o_perf_illegal
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    decoded_t        in_fields;
    logic [XLEN-1:0] in_imm;

    decoded_t        ent_q [DEPTH];
    decoded_t        ent_d [DEPTH];
    logic [XLEN-1:0] imm_q [DEPTH];
    logic [XLEN-1:0] imm_d [DEPTH];
    logic [XLEN-1:0] pc_q  [DEPTH];
    logic [XLEN-1:0] pc_d  [DEPTH];

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;

    logic     push;
    logic     pop;
    decoded_t head;

    decode_fields #(
        .XLEN (XLEN)
    ) u_fields (
        .i_instruction (i_instruction),
        .o_fields      (in_fields),
        .o_imm         (in_imm)
    );

    assign o_ready = (count_q < DEPTH_C) && rst_n;
    assign o_valid = (count_q != '0);
    assign o_count = count_q;

    // Flush cancels both sides of the handshake for the cycle it is asserted.
    always_comb begin
        push     = i_valid && o_ready && !i_flush;
        pop      = o_valid && i_ready && !i_flush;
        ent_d    = ent_q;
        imm_d    = imm_q;
        pc_d     = pc_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        count_d  = count_q;
        if (push) begin
            ent_d[wptr_q] = in_fields;
            imm_d[wptr_q] = in_imm;
            pc_d[wptr_q]  = i_pc;
        end
        if (i_flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + 1'b1;
            if (pop)  rptr_d = rptr_q + 1'b1;
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: contents are only observable behind count.
    always_ff @(posedge clk) begin
        ent_q <= ent_d;
        imm_q <= imm_d;
        pc_q  <= pc_d;
    end

    always_comb begin
        head      = ent_q[rptr_q];
        o_pc      = '0;
        o_opcode  = '0;
        o_funct7  = '0;
        o_funct3  = '0;
        o_rs1     = '0;
        o_rs2     = '0;
        o_rd      = '0;
        o_imm     = '0;
        o_type    = TYPE_ERROR;
        o_illegal = 1'b0;
        if (o_valid) begin
            o_pc      = pc_q[rptr_q];
            o_opcode  = head.opcode;
            o_funct7  = head.funct7;
            o_funct3  = head.funct3;
            o_rs1     = head.rs1;
            o_rs2     = head.rs2;
            o_rd      = head.rd;
            o_imm     = imm_q[rptr_q];
            o_type    = head.typ;
            o_illegal = head.illegal;
        end
    end

`ifdef DECODE_PERF_EN
    logic [31:0] perf_dec_q, perf_dec_d;
    logic [31:0] perf_ill_q, perf_ill_d;

    always_comb begin
        perf_dec_d = perf_dec_q + 32'(push);
        perf_ill_d = perf_ill_q + 32'(push && in_fields.illegal);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_dec_q <= '0;
            perf_ill_q <= '0;
        end else begin
            perf_dec_q <= perf_dec_d;
            perf_ill_q <= perf_ill_d;
        end
    end

    assign o_perf_decoded = perf_dec_q;
    assign o_perf_illegal = perf_ill_q;
`endif

endmodule
